multiword_cla_sequencer: RTL and testbench



---
 rtl/multiword_cla_sequencer.sv | 178 +++++++++++++++++
 tb/tb_multiword_cla_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_cla_sequencer.sv
// Multi-cycle wide adder that reuses one 16-bit carry-lookahead slice,
// processing one 16-bit chunk per clock from LSB to MSB.

module carry_lookahead_adder_16bits (
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        pg,
    output logic        gg
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_c;

    assign g = in0 & in1;
    assign p = in0 ^ in1;

    // Two-level lookahead: 4-bit groups, then a lookahead unit across the groups.
    for (genvar k = 0; k < 4; k++) begin : g_group
        localparam int B = 4 * k;

        assign grp_p[k] = &p[B+3:B];
        assign grp_g[k] = g[B+3]
                        | (p[B+3] & g[B+2])
                        | (p[B+3] & p[B+2] & g[B+1])
                        | (p[B+3] & p[B+2] & p[B+1] & g[B]);

        assign c[B]   = grp_c[k];
        assign c[B+1] = g[B] | (p[B] & grp_c[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & grp_c[k]);
    end

    assign grp_c[0] = carry_in;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & carry_in);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & carry_in);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & carry_in);

    assign pg  = &grp_p;
    assign gg  = grp_g[3]
               | (grp_p[3] & grp_g[2])
               | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    assign sum = p ^ c;

endmodule

module multiword_cla_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNKS = WIDTH / 16;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             out_valid_reg;

    logic [15:0]      a_chunks [CHUNKS];
    logic [15:0]      b_chunks [CHUNKS];
    logic [15:0]      slice_sum;
    logic             slice_pg;
    logic             slice_gg;
    logic             next_carry;
    logic             accept;

    for (genvar i = 0; i < CHUNKS; i++) begin : g_chunk
        assign a_chunks[i] = a_reg[16*i +: 16];
        assign b_chunks[i] = b_reg[16*i +: 16];
    end

    carry_lookahead_adder_16bits u_slice (
        .in0      (a_chunks[cnt]),
        .in1      (b_chunks[cnt]),
        .carry_in (carry),
        .sum      (slice_sum),
        .pg       (slice_pg),
        .gg       (slice_gg)
    );

    assign next_carry = slice_gg | (slice_pg & carry);
    // A finished result can be handed off and a new pair taken on the same edge.
    assign in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < CHUNKS; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            sum_reg[16*i +: 16] <= slice_sum;
                        end
                    end
                    carry <= next_carry;
                    if (cnt == LAST) begin
                        cout_reg      <= next_carry;
                        ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                       & (slice_sum[15] != a_reg[WIDTH-1]);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (in_valid) begin
                            a_reg <= a;
                            b_reg <= b;
                            carry <= cin;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_multiword_cla_sequencer.sv
// Self-checking bench for multiword_cla_sequencer: directed vector table,
// backpressure / back-to-back / mid-operation reset sequences, random stream.

module tb_multiword_cla_sequencer;

    localparam int WIDTH  = 64;
    localparam int CHUNKS = WIDTH / 16;
    localparam logic signed [65:0] SMAX = (66'sd1 <<< 63) - 66'sd1;
    localparam logic signed [65:0] SMIN = -(66'sd1 <<< 63);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } result_t;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    int      checks = 0;
    int      failures = 0;
    int      cycle = 0;
    int      hs_count = 0;
    int      hs_cycles[$];
    result_t exp_q[$];
    result_t mon_e;
    vec_t    vecs[6];

    multiword_cla_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: plain unsigned and signed arithmetic on widened operands.
    function automatic result_t model(input logic [63:0] x, input logic [63:0] y, input logic ci);
        result_t           r;
        logic [64:0]       full;
        logic signed [65:0] s;
        full   = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        s      = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, ci});
        r.sum  = full[63:0];
        r.cout = full[64];
        r.ovf  = (s > SMAX) || (s < SMIN);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Scoreboard: handshakes are observed on the falling edge and take effect on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                hs_count++;
                hs_cycles.push_back(cycle + 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_result actual=%h expected=none", sum);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("sb_sum", sum, mon_e.sum);
                    checkOutput("sb_cout", 64'(cout), 64'(mon_e.cout));
                    checkOutput("sb_ovf", 64'(ovf), 64'(mon_e.ovf));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
        end
    end

    task automatic reset_dut();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_sum", sum, 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checkOutput({v.name, "_ready"}, 64'(in_ready), 64'd1);
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; cin = 1'($urandom());
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkOutput({v.name, "_latency"}, 64'(n), 64'(CHUNKS));
        checkOutput({v.name, "_sum"}, sum, v.sum);
        checkOutput({v.name, "_cout"}, 64'(cout), 64'(v.cout));
        checkOutput({v.name, "_ovf"}, 64'(ovf), 64'(v.ovf));
        @(posedge clk); #1;
    endtask

    task automatic stream_ops(input int n, input int stall_pct);
        int   acc;
        int   guard;
        logic will;
        acc = 0; guard = 0;
        a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; cin = 1'($urandom());
        in_valid = 1'b1;
        while (acc < n && guard < n * 20 + 50) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            #1;
            will = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (will) begin
                acc++;
                a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; cin = 1'($urandom());
                if (acc >= n) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_accepts", 64'(acc), 64'(n));
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checkOutput("stream_drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        result_t r;
        int      hs_before;
        int      base;

        vecs[0] = '{"ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{"posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2] = '{"negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[3] = '{"cinonly", 64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
        vecs[4] = '{"chunkcarry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0, 1'b0};
        vecs[5] = '{"allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

        reset_dut();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Backpressure: result must hold while downstream stalls.
        out_ready = 1'b0;
        a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; cin = 1'($urandom());
        r = model(a, b, cin);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (CHUNKS) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
            in_valid = 1'($urandom());
            @(posedge clk); #1;
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_sum", sum, r.sum);
            checkOutput("bp_cout", 64'(cout), 64'(r.cout));
            checkOutput("bp_ovf", 64'(ovf), 64'(r.ovf));
        end
        in_valid  = 1'b0;
        hs_before = hs_count;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_handoffs", 64'(hs_count - hs_before), 64'd1);

        // Back-to-back: handoff and next accept share an edge, so handoffs are CHUNKS+1 edges apart.
        base = hs_cycles.size();
        stream_ops(3, 0);
        checkOutput("b2b_count", 64'(hs_cycles.size() - base), 64'd3);
        if (hs_cycles.size() >= base + 3) begin
            checkOutput("b2b_gap1", 64'(hs_cycles[base+1] - hs_cycles[base]), 64'(CHUNKS + 1));
            checkOutput("b2b_gap2", 64'(hs_cycles[base+2] - hs_cycles[base+1]), 64'(CHUNKS + 1));
        end

        // Mid-operation reset at cnt==2 discards the operation.
        @(posedge clk); #1;
        out_ready = 1'b1;
        a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; cin = 1'($urandom());
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hs_before = hs_count;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("midrst_no_result", 64'(hs_count - hs_before), 64'd0);
        checkOutput("midrst_idle_valid", 64'(out_valid), 64'd0);

        stream_ops(10000, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
